// File: rtl/sync_fifo_flags_pkg.sv
// Shared helpers for the flagged FIFO: sizing functions and flag-bundle bit positions.
package fifo_pkg;

   localparam int unsigned FLAG_EMPTY  = 0;
   localparam int unsigned FLAG_FULL   = 1;
   localparam int unsigned FLAG_AEMPTY = 2;
   localparam int unsigned FLAG_AFULL  = 3;
   localparam int unsigned FLAG_W      = 4;

   function automatic int unsigned fifo_clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

   function automatic int unsigned depth_of(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

   // Occupancy must represent 0..DEPTH inclusive, hence DEPTH+1 states.
   function automatic int unsigned level_width(input int unsigned aw);
      return fifo_clog2(depth_of(aw) + 1);
   endfunction

endpackage

// File: rtl/sync_fifo_flags_mem.sv
// Two-port storage array: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem_2p #(
   parameter int unsigned DATA_WIDTH    = 4,
   parameter int unsigned ADDRESS_WIDTH = 5,
   parameter int unsigned DEPTH         = 32
) (
   input  logic                     clk,
   input  logic                     write_enable,
   input  logic [ADDRESS_WIDTH-1:0] write_address,
   input  logic [DATA_WIDTH-1:0]    write_data,
   input  logic [ADDRESS_WIDTH-1:0] read_address,
   output logic [DATA_WIDTH-1:0]    read_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (write_enable) mem_q[write_address] <= write_data;
   end

   assign read_data = mem_q[read_address];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky errors,
// flush and a choice of first-word-fall-through or registered read.
module sync_fifo_flags
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 4,
   parameter int unsigned ADDRESS_WIDTH = 5,
   parameter int unsigned AF_THRESHOLD  = depth_of(ADDRESS_WIDTH) - 2,
   parameter int unsigned AE_THRESHOLD  = 1,
   parameter int unsigned FWFT          = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DATA_WIDTH-1:0]  write_data,
   input  logic                   write_increment,
   input  logic                   read_increment,
   input  logic                   flush,
   input  logic                   clear_errors,
   output logic [DATA_WIDTH-1:0]  read_data,
   output logic                   empty,
   output logic                   full,
   output logic                   almost_empty,
   output logic                   almost_full,
   output logic [ADDRESS_WIDTH:0] level,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int unsigned DEPTH = depth_of(ADDRESS_WIDTH);
   localparam int unsigned LW    = level_width(ADDRESS_WIDTH);

   localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] AF_LVL    = LW'(AF_THRESHOLD);
   localparam logic [LW-1:0] AE_LVL    = LW'(AE_THRESHOLD);

   if (ADDRESS_WIDTH < 1) begin : g_bad_aw
      $error("sync_fifo_flags: ADDRESS_WIDTH must be >= 1");
   end
   if (!(AE_THRESHOLD < AF_THRESHOLD && AF_THRESHOLD <= DEPTH)) begin : g_bad_thr
      $error("sync_fifo_flags: need AE_THRESHOLD < AF_THRESHOLD <= DEPTH");
   end

   logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]            level_q, level_d;
   logic [FLAG_W-1:0]        flags_q, flags_d;
   logic                     overflow_q, overflow_d;
   logic                     underflow_q, underflow_d;
   logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;

   logic                     read_accept;
   logic                     write_accept;
   logic                     mem_we;
   logic [DATA_WIDTH-1:0]    mem_rdata;

   fifo_mem_2p #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDRESS_WIDTH(ADDRESS_WIDTH),
      .DEPTH        (DEPTH)
   ) u_mem (
      .clk          (clk),
      .write_enable (mem_we),
      .write_address(wr_ptr_q),
      .write_data   (write_data),
      .read_address (rd_ptr_q),
      .read_data    (mem_rdata)
   );

   always_comb begin
      read_accept  = read_increment & ~flags_q[FLAG_EMPTY];
      write_accept = write_increment & (~flags_q[FLAG_FULL] | read_accept);
      mem_we       = write_accept & ~flush & ~reset;

      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      overflow_d   = overflow_q;
      underflow_d  = underflow_q;
      read_data_d  = read_data_q;

      // Flush drops same-cycle traffic silently: no pointer moves, no error events.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (write_accept) wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(1);
         if (read_accept)  rd_ptr_d = rd_ptr_q + ADDRESS_WIDTH'(1);
         level_d     = level_q + LW'(write_accept) - LW'(read_accept);
         overflow_d  = (overflow_q & ~clear_errors) | (write_increment & ~write_accept);
         underflow_d = (underflow_q & ~clear_errors) | (read_increment & flags_q[FLAG_EMPTY]);
         if (read_accept) read_data_d = mem_rdata;
      end

      flags_d              = '0;
      flags_d[FLAG_EMPTY]  = (level_d == '0);
      flags_d[FLAG_FULL]   = (level_d == DEPTH_LVL);
      flags_d[FLAG_AEMPTY] = (level_d <= AE_LVL);
      flags_d[FLAG_AFULL]  = (level_d >= AF_LVL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q             <= '0;
         rd_ptr_q             <= '0;
         level_q              <= '0;
         flags_q              <= '0;
         flags_q[FLAG_EMPTY]  <= 1'b1;
         flags_q[FLAG_AEMPTY] <= 1'b1;
         overflow_q           <= 1'b0;
         underflow_q          <= 1'b0;
         read_data_q          <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         flags_q     <= flags_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         read_data_q <= read_data_d;
      end
   end

   always_comb begin
      if (FWFT != 0) read_data = flags_q[FLAG_EMPTY] ? '0 : mem_rdata;
      else           read_data = read_data_q;
   end

   assign empty        = flags_q[FLAG_EMPTY];
   assign full         = flags_q[FLAG_FULL];
   assign almost_empty = flags_q[FLAG_AEMPTY];
   assign almost_full  = flags_q[FLAG_AFULL];
   assign level        = level_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives an FWFT and a registered-read FIFO with identical traffic and checks both against a queue model.
module tb_sync_fifo_flags;

   localparam int DW    = 4;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 1;

   logic          clk = 1'b0;
   logic          reset, write_increment, read_increment, flush, clear_errors;
   logic [DW-1:0] write_data;

   logic [DW-1:0] read_data_1, read_data_0;
   logic          empty_1, full_1, aempty_1, afull_1, ovf_1, udf_1;
   logic          empty_0, full_0, aempty_0, afull_0, ovf_0, udf_0;
   logic [AW:0]   level_1, level_0;

   always #5 clk = ~clk;

   sync_fifo_flags #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .AF_THRESHOLD(AF), .AE_THRESHOLD(AE), .FWFT(1)
   ) u_fwft (
      .clk(clk), .reset(reset), .write_data(write_data), .write_increment(write_increment),
      .read_increment(read_increment), .flush(flush), .clear_errors(clear_errors),
      .read_data(read_data_1), .empty(empty_1), .full(full_1), .almost_empty(aempty_1),
      .almost_full(afull_1), .level(level_1), .overflow(ovf_1), .underflow(udf_1)
   );

   sync_fifo_flags #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .AF_THRESHOLD(AF), .AE_THRESHOLD(AE), .FWFT(0)
   ) u_reg (
      .clk(clk), .reset(reset), .write_data(write_data), .write_increment(write_increment),
      .read_increment(read_increment), .flush(flush), .clear_errors(clear_errors),
      .read_data(read_data_0), .empty(empty_0), .full(full_0), .almost_empty(aempty_0),
      .almost_full(afull_0), .level(level_0), .overflow(ovf_0), .underflow(udf_0)
   );

   int errors = 0;
   int checks = 0;

   int model_q[$];
   int exp_q1[$];
   int exp_q0[$];
   bit m_ovf, m_udf;
   int last0;
   bit pend0 = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic chk_dut(input string tag, input logic [AW:0] lvl, input logic emp, input logic ful,
                          input logic ae, input logic af, input logic ov, input logic ud);
      int n;
      n = model_q.size();
      chk({tag, "_level"},        32'(lvl), n);
      chk({tag, "_empty"},        32'(emp), 32'(n == 0));
      chk({tag, "_full"},         32'(ful), 32'(n == DEPTH));
      chk({tag, "_almost_empty"}, 32'(ae),  32'(n <= AE));
      chk({tag, "_almost_full"},  32'(af),  32'(n >= AF));
      chk({tag, "_overflow"},     32'(ov),  32'(m_ovf));
      chk({tag, "_underflow"},    32'(ud),  32'(m_udf));
   endtask

   // One clock of stimulus; the model advances by the FIFO rules on the pre-edge state.
   task automatic step(input bit wr, input int wd, input bit rd,
                       input bit fl = 0, input bit ce = 0, input bit rst = 0);
      bit ra, wa, ev_ov, ev_ud;
      int h;
      reset           = rst;
      write_increment = wr;
      write_data      = DW'(wd);
      read_increment  = rd;
      flush           = fl;
      clear_errors    = ce;
      if (rst) begin
         model_q.delete();
         m_ovf = 0;
         m_udf = 0;
         last0 = 0;
      end else if (fl) begin
         model_q.delete();
      end else begin
         ra    = rd && (model_q.size() > 0);
         wa    = wr && ((model_q.size() < DEPTH) || ra);
         ev_ov = wr && !wa;
         ev_ud = rd && (model_q.size() == 0);
         if (ra) begin
            h = model_q.pop_front();
            exp_q1.push_back(h);
            exp_q0.push_back(h);
            last0 = h;
         end
         if (wa) model_q.push_back(wd & ((1 << DW) - 1));
         m_ovf = (m_ovf && !ce) || ev_ov;
         m_udf = (m_udf && !ce) || ev_ud;
      end
      @(posedge clk);
      #1;
      chk_dut("fwft", level_1, empty_1, full_1, aempty_1, afull_1, ovf_1, udf_1);
      chk_dut("reg",  level_0, empty_0, full_0, aempty_0, afull_0, ovf_0, udf_0);
      chk("fwft_head", 32'(read_data_1), (model_q.size() > 0) ? model_q[0] : 0);
      chk("reg_read_data_hold", 32'(read_data_0), last0);
   endtask

   // Monitor: FWFT data is valid during the popping cycle, registered data one cycle later.
   always @(negedge clk) begin
      if (!reset && !flush && read_increment && !empty_1) begin
         if (exp_q1.size() == 0) chk("sb_fwft_queue", 0, 1);
         else chk("sb_fwft_data", 32'(read_data_1), exp_q1.pop_front());
      end
      if (pend0) begin
         if (exp_q0.size() == 0) chk("sb_reg_queue", 0, 1);
         else chk("sb_reg_data", 32'(read_data_0), exp_q0.pop_front());
      end
      pend0 = !reset && !flush && read_increment && !empty_0;
   end

   initial begin
      bit wr, rd, fl, ce;
      int pw;
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0);

      for (int i = 1; i <= 8; i++) step(1, i, 0);
      step(1, 9, 0);
      step(1, 11, 1);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) step(0, 0, 1);
      step(0, 0, 1);
      step(1, 10, 1);
      step(0, 0, 0, 0, 1);
      for (int i = 1; i <= 4; i++) step(1, i + 2, 0);
      step(1, 15, 1, 1);
      step(0, 0, 0);

      for (int ph = 0; ph < 6; ph++) begin
         if (ph == 3) step(1, 5, 1, 0, 0, 1);
         pw = (ph % 2 == 0) ? 75 : 30;
         for (int i = 0; i < 40; i++) begin
            wr = ($urandom_range(0, 99) < pw);
            rd = ($urandom_range(0, 99) < (100 - pw));
            fl = ($urandom_range(0, 99) < 2);
            ce = !fl && ($urandom_range(0, 99) < 5);
            step(wr, int'($urandom_range(0, 15)), rd, fl, ce);
         end
      end

      step(0, 0, 0);
      step(0, 0, 0);
      @(negedge clk);
      chk("sb_fwft_leftover", exp_q1.size(), 0);
      chk("sb_reg_leftover",  exp_q0.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
